// File: rtl/bkm_iter_ctrl_if.sv
// Handshake and step-control bundle between the BKM iteration controller
// and its upstream producer / datapath / downstream consumer.
interface bkm_iter_ctrl_if #(
   parameter int unsigned WN = 7
) ();
   logic          in_valid;
   logic          in_ready;
   logic [WN-1:0] n_iter_cfg;
   logic          load_en;
   logic          step_en;
   logic [WN-1:0] step_n;
   logic          out_valid;
   logic          out_ready;

   // Producer / consumer / datapath side
   modport master (
      output in_valid, n_iter_cfg, out_ready,
      input  in_ready, load_en, step_en, step_n, out_valid
   );

   // Controller side
   modport slave (
      input  in_valid, n_iter_cfg, out_ready,
      output in_ready, load_en, step_en, step_n, out_valid
   );
endinterface

// File: rtl/bkm_iter_ctrl.sv
// BKM iteration controller: accepts an operand set, issues one bkm_step per
// enabled cycle for the (saturated) requested iteration count, then holds
// the result valid until the consumer takes it.
// Optional macro BKM_CTRL_EARLY_ACCEPT_EN: accept the next operand set in
// DONE while the current result is being taken (no IDLE bubble).
module bkm_iter_ctrl #(
   parameter int unsigned N_MAX = 64,
   parameter int unsigned WN    = 7
) (
   input logic            clk,
   input logic            arst_n,
   input logic            srst,
   input logic            enable,
   bkm_iter_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [WN-1:0] CNT_MAX = WN'(N_MAX);
   localparam logic [WN-1:0] CNT_ONE = WN'(1);

   state_t        state_q, state_d;
   logic [WN-1:0] n_q, n_d;
   logic [WN-1:0] count_q, count_d;
   logic [WN-1:0] cfg_sat;

   // Requested count clamped to the legal range [1, N_MAX]
   always_comb begin
      if (bus.n_iter_cfg == '0) begin
         cfg_sat = CNT_ONE;
      end else if (bus.n_iter_cfg > CNT_MAX) begin
         cfg_sat = CNT_MAX;
      end else begin
         cfg_sat = bus.n_iter_cfg;
      end
   end

   // Next-state, iteration index and strobe generation
   always_comb begin
      state_d     = state_q;
      n_d         = n_q;
      count_d     = count_q;
      bus.load_en = 1'b0;
      bus.step_en = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (enable && bus.in_valid) begin
               bus.load_en = 1'b1;
               count_d     = cfg_sat;
               n_d         = '0;
               state_d     = ITER;
            end
         end
         ITER: begin
            bus.step_en = enable;
            if (enable) begin
               if (n_q == count_q - CNT_ONE) begin
                  state_d = DONE;
               end else begin
                  n_d = n_q + CNT_ONE;
               end
            end
         end
         DONE: begin
            if (enable && bus.out_ready) begin
`ifdef BKM_CTRL_EARLY_ACCEPT_EN
               if (bus.in_valid) begin
                  bus.load_en = 1'b1;
                  count_d     = cfg_sat;
                  n_d         = '0;
                  state_d     = ITER;
               end else begin
                  n_d     = '0;
                  state_d = IDLE;
               end
`else
               n_d     = '0;
               state_d = IDLE;
`endif
            end
         end
         default: begin
            n_d     = '0;
            state_d = IDLE;
         end
      endcase

      // Synchronous reset overrides any handshake in the same cycle
      if (srst) begin
         state_d     = IDLE;
         n_d         = '0;
         count_d     = CNT_ONE;
         bus.load_en = 1'b0;
      end
   end

   // State-derived outputs; n is cleared on leaving DONE so step_n reads 0 in IDLE
   always_comb begin
`ifdef BKM_CTRL_EARLY_ACCEPT_EN
      bus.in_ready = (state_q == IDLE) || (state_q == DONE);
`else
      bus.in_ready = (state_q == IDLE);
`endif
      bus.out_valid = (state_q == DONE);
      bus.step_n    = n_q;
   end

   // State registers; enable gating is folded into the _d logic
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q <= IDLE;
         n_q     <= '0;
         count_q <= CNT_ONE;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         count_q <= count_d;
      end
   end

endmodule

// File: tb/tb_bkm_iter_ctrl.sv
// Self-checking bench for bkm_iter_ctrl: directed scenarios plus randomized
// transactions checked against a transaction-level reference model.
module tb_bkm_iter_ctrl;
   localparam int unsigned N_MAX   = 64;
   localparam int unsigned WN      = 7;
   localparam int          TIMEOUT = 300;

   logic clk = 1'b0;
   logic arst_n, srst, enable;
   int   n_checks = 0;
   int   n_fail   = 0;

   bkm_iter_ctrl_if #(.WN(WN)) bus ();

   bkm_iter_ctrl #(.N_MAX(N_MAX), .WN(WN)) dut (
      .clk    (clk),
      .arst_n (arst_n),
      .srst   (srst),
      .enable (enable),
      .bus    (bus.slave)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   // Reference: effective iteration count from the requested one
   function automatic int exp_count(input int cfg);
      if (cfg == 0) return 1;
      if (cfg > int'(N_MAX)) return int'(N_MAX);
      return cfg;
   endfunction

   // Drives one operation from IDLE and records what the DUT did.
   task automatic do_op(input logic [WN-1:0] cfg, input int stall_at, input int stall_len,
                        input int ready_delay, input bit finish,
                        output int loads, output int lat, output int steps,
                        output logic [WN-1:0] last_n, output bit seq_ok, output bit hold_ok);
      int stall_left;
      loads = 0; lat = 0; steps = 0; last_n = '0; seq_ok = 1'b1; hold_ok = 1'b1;
      stall_left = stall_len;
      enable = 1'b1; bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.n_iter_cfg = cfg;
      #1;
      if (bus.load_en === 1'b1) loads++;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      while (bus.out_valid !== 1'b1 && lat < TIMEOUT) begin
         bus.in_valid   = 1'($urandom_range(0, 1));
         bus.n_iter_cfg = WN'($urandom_range(0, 127));
         if (steps == stall_at && stall_left > 0) begin
            enable = 1'b0;
            stall_left--;
         end else begin
            enable = 1'b1;
         end
         #1;
         if (bus.load_en === 1'b1) loads++;
         if (bus.in_ready !== 1'b0) seq_ok = 1'b0;
         if (enable) begin
            if (bus.step_en !== 1'b1 || bus.step_n !== WN'(steps)) seq_ok = 1'b0;
            last_n = bus.step_n;
            steps++;
         end else if (bus.step_en !== 1'b0 || bus.step_n !== WN'(steps)) begin
            seq_ok = 1'b0;
         end
         @(posedge clk); #1;
         lat++;
      end
      enable = 1'b1; bus.in_valid = 1'b0;
      for (int i = 0; i < ready_delay; i++) begin
         bus.in_valid = 1'($urandom_range(0, 1));
         #1;
         if (bus.out_valid !== 1'b1 || bus.load_en !== 1'b0 || bus.step_en !== 1'b0) hold_ok = 1'b0;
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      if (finish) begin
         bus.out_ready = 1'b1;
         #1;
         if (bus.out_valid !== 1'b1) hold_ok = 1'b0;
         @(posedge clk); #1;
         bus.out_ready = 1'b0;
      end
   endtask

   task automatic test_reset();
      arst_n = 1'b0; srst = 1'b0; enable = 1'b0;
      bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.n_iter_cfg = '0;
      #3;
      n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
      n_checks++; if ({bus.load_en, bus.step_en, bus.out_valid} !== 3'b000) begin n_fail++; $display("FAIL reset_strobes: got %b expected 000", {bus.load_en, bus.step_en, bus.out_valid}); end
      n_checks++; if (bus.step_n !== '0) begin n_fail++; $display("FAIL reset_step_n: got %0d expected 0", bus.step_n); end
      @(posedge clk); #1; arst_n = 1'b1; enable = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      int loads, lat, steps; logic [WN-1:0] last_n; bit seq_ok, hold_ok;
      do_op(WN'(4), 99, 0, 0, 1'b1, loads, lat, steps, last_n, seq_ok, hold_ok);
      n_checks++; if (loads !== 1) begin n_fail++; $display("FAIL basic_loads: got %0d expected 1", loads); end
      n_checks++; if (steps !== 4) begin n_fail++; $display("FAIL basic_steps: got %0d expected 4", steps); end
      n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL basic_latency: got %0d expected 4", lat); end
      n_checks++; if (seq_ok !== 1'b1) begin n_fail++; $display("FAIL basic_step_seq: got %b expected 1", seq_ok); end
      n_checks++; if (last_n !== WN'(3)) begin n_fail++; $display("FAIL basic_last_n: got %0d expected 3", last_n); end
      n_checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_back_idle: got in_ready=%b out_valid=%b expected 1/0", bus.in_ready, bus.out_valid); end
   endtask

   task automatic test_saturation();
      int loads, lat, steps; logic [WN-1:0] last_n; bit seq_ok, hold_ok;
      do_op(WN'(0), 99, 0, 0, 1'b1, loads, lat, steps, last_n, seq_ok, hold_ok);
      n_checks++; if (steps !== 1 || lat !== 1) begin n_fail++; $display("FAIL sat_zero: got steps=%0d lat=%0d expected 1/1", steps, lat); end
      do_op(WN'(100), 99, 0, 0, 1'b1, loads, lat, steps, last_n, seq_ok, hold_ok);
      n_checks++; if (steps !== 64 || lat !== 64) begin n_fail++; $display("FAIL sat_max: got steps=%0d lat=%0d expected 64/64", steps, lat); end
      n_checks++; if (last_n !== WN'(63) || seq_ok !== 1'b1) begin n_fail++; $display("FAIL sat_last_n: got %0d seq=%b expected 63 seq=1", last_n, seq_ok); end
   endtask

   task automatic test_stall();
      int loads, lat, steps; logic [WN-1:0] last_n; bit seq_ok, hold_ok;
      do_op(WN'(8), 2, 3, 0, 1'b1, loads, lat, steps, last_n, seq_ok, hold_ok);
      n_checks++; if (lat !== 11) begin n_fail++; $display("FAIL stall_latency: got %0d expected 11", lat); end
      n_checks++; if (steps !== 8 || seq_ok !== 1'b1) begin n_fail++; $display("FAIL stall_steps: got %0d seq=%b expected 8 seq=1", steps, seq_ok); end
   endtask

   task automatic test_enable_freeze();
      int loads, lat, steps; logic [WN-1:0] last_n; bit seq_ok, hold_ok;
      enable = 1'b0; bus.in_valid = 1'b1; bus.n_iter_cfg = WN'(5); #1;
      n_checks++; if (bus.load_en !== 1'b0) begin n_fail++; $display("FAIL freeze_idle_load: got %b expected 0", bus.load_en); end
      @(posedge clk); #1; bus.in_valid = 1'b0; #1;
      n_checks++; if (bus.in_ready !== 1'b1 || bus.step_en !== 1'b0) begin n_fail++; $display("FAIL freeze_idle_state: got in_ready=%b step_en=%b expected 1/0", bus.in_ready, bus.step_en); end
      do_op(WN'(1), 99, 0, 0, 1'b0, loads, lat, steps, last_n, seq_ok, hold_ok);
      enable = 1'b0; bus.out_ready = 1'b1; #1;
      @(posedge clk); #1;
      n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL freeze_done_hold: got %b expected 1", bus.out_valid); end
      enable = 1'b1; @(posedge clk); #1; bus.out_ready = 1'b0;
      n_checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL freeze_release: got in_ready=%b out_valid=%b expected 1/0", bus.in_ready, bus.out_valid); end
   endtask

   task automatic test_done_hold_srst();
      int loads, lat, steps; logic [WN-1:0] last_n; bit seq_ok, hold_ok;
      do_op(WN'(3), 99, 0, 10, 1'b0, loads, lat, steps, last_n, seq_ok, hold_ok);
      n_checks++; if (hold_ok !== 1'b1 || loads !== 1) begin n_fail++; $display("FAIL done_hold: got hold=%b loads=%0d expected 1/1", hold_ok, loads); end
      srst = 1'b1; enable = 1'b0; bus.out_ready = 1'b1; bus.in_valid = 1'b1; #1;
      @(posedge clk); #1;
      srst = 1'b0; enable = 1'b1; bus.out_ready = 1'b0; bus.in_valid = 1'b0; #1;
      n_checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.step_n !== '0) begin n_fail++; $display("FAIL srst_done: got in_ready=%b out_valid=%b step_n=%0d expected 1/0/0", bus.in_ready, bus.out_valid, bus.step_n); end
      srst = 1'b1; bus.in_valid = 1'b1; bus.n_iter_cfg = WN'(4); #1;
      n_checks++; if (bus.load_en !== 1'b0) begin n_fail++; $display("FAIL srst_load: got %b expected 0", bus.load_en); end
      @(posedge clk); #1; srst = 1'b0; bus.in_valid = 1'b0; #1;
      n_checks++; if (bus.in_ready !== 1'b1 || bus.step_en !== 1'b0) begin n_fail++; $display("FAIL srst_accept_blocked: got in_ready=%b step_en=%b expected 1/0", bus.in_ready, bus.step_en); end
   endtask

   task automatic test_async_mid_iter();
      bit seen_valid;
      enable = 1'b1; bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.n_iter_cfg = WN'(10); #1;
      @(posedge clk); #1; bus.in_valid = 1'b0;
      for (int i = 0; i < 20 && bus.step_n !== WN'(5); i++) begin
         @(posedge clk); #1;
      end
      n_checks++; if (bus.step_n !== WN'(5) || bus.step_en !== 1'b1) begin n_fail++; $display("FAIL arst_reach_n5: got step_n=%0d step_en=%b expected 5/1", bus.step_n, bus.step_en); end
      #2; arst_n = 1'b0; #1;
      n_checks++; if (bus.in_ready !== 1'b1 || {bus.load_en, bus.step_en, bus.out_valid} !== 3'b000 || bus.step_n !== '0) begin n_fail++; $display("FAIL arst_immediate: got in_ready=%b strobes=%b step_n=%0d expected 1/000/0", bus.in_ready, {bus.load_en, bus.step_en, bus.out_valid}, bus.step_n); end
      @(posedge clk); #1; arst_n = 1'b1; bus.out_ready = 1'b1;
      seen_valid = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (bus.out_valid !== 1'b0 || bus.step_en !== 1'b0) seen_valid = 1'b1;
      end
      bus.out_ready = 1'b0;
      n_checks++; if (seen_valid !== 1'b0) begin n_fail++; $display("FAIL arst_abandon: got activity=%b expected 0", seen_valid); end
   endtask

   task automatic test_back_to_back();
      int loads, lat, steps; logic [WN-1:0] last_n; bit seq_ok, hold_ok;
      do_op(WN'(2), 99, 0, 0, 1'b0, loads, lat, steps, last_n, seq_ok, hold_ok);
      bus.in_valid = 1'b1; bus.n_iter_cfg = WN'(3); bus.out_ready = 1'b1; enable = 1'b1; #1;
`ifdef BKM_CTRL_EARLY_ACCEPT_EN
      n_checks++; if (bus.load_en !== 1'b1 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_early_load: got load_en=%b in_ready=%b expected 1/1", bus.load_en, bus.in_ready); end
      @(posedge clk); #1; bus.in_valid = 1'b0; bus.out_ready = 1'b0; #1;
`else
      n_checks++; if (bus.load_en !== 1'b0 || bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_done_load: got load_en=%b in_ready=%b expected 0/0", bus.load_en, bus.in_ready); end
      @(posedge clk); #1; bus.out_ready = 1'b0; #1;
      n_checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.load_en !== 1'b1) begin n_fail++; $display("FAIL b2b_idle_bubble: got in_ready=%b out_valid=%b load_en=%b expected 1/0/1", bus.in_ready, bus.out_valid, bus.load_en); end
      @(posedge clk); #1; bus.in_valid = 1'b0; #1;
`endif
      n_checks++; if (bus.step_en !== 1'b1 || bus.step_n !== '0) begin n_fail++; $display("FAIL b2b_first_step: got step_en=%b step_n=%0d expected 1/0", bus.step_en, bus.step_n); end
      lat = 0;
      while (bus.out_valid !== 1'b1 && lat < TIMEOUT) begin
         @(posedge clk); #1; lat++;
      end
      n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL b2b_second_latency: got %0d expected 3", lat); end
      bus.out_ready = 1'b1; @(posedge clk); #1; bus.out_ready = 1'b0;
   endtask

   task automatic test_random();
      int loads, lat, steps, cnt, exp_lat, st_at, st_len, rd, cfg;
      logic [WN-1:0] last_n; bit seq_ok, hold_ok;
      for (int t = 0; t < 20; t++) begin
         cfg    = int'($urandom_range(0, 100));
         st_at  = int'($urandom_range(0, 70));
         st_len = int'($urandom_range(0, 3));
         rd     = int'($urandom_range(0, 4));
         do_op(WN'(cfg), st_at, st_len, rd, 1'b1, loads, lat, steps, last_n, seq_ok, hold_ok);
         cnt     = exp_count(cfg);
         exp_lat = cnt + ((st_at < cnt) ? st_len : 0);
         n_checks++; if (steps !== cnt || last_n !== WN'(cnt - 1)) begin n_fail++; $display("FAIL rand_steps[%0d]: got steps=%0d last=%0d expected %0d/%0d", t, steps, last_n, cnt, cnt - 1); end
         n_checks++; if (lat !== exp_lat) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", t, lat, exp_lat); end
         n_checks++; if (loads !== 1 || seq_ok !== 1'b1 || hold_ok !== 1'b1) begin n_fail++; $display("FAIL rand_protocol[%0d]: got loads=%0d seq=%b hold=%b expected 1/1/1", t, loads, seq_ok, hold_ok); end
         n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rand_idle[%0d]: got %b expected 1", t, bus.in_ready); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_saturation();
      test_stall();
      test_enable_freeze();
      test_done_hold_srst();
      test_async_mid_iter();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/bkm_iter_ctrl.md
BKM_ITER_CTRL -- requirements
Module: bkm_iter_ctrl

Interface
REQ-001 The block SHALL have parameter N_MAX, default 64: maximum BKM iteration count; one iteration per bkm_step activation.
REQ-002 The block SHALL have parameter WN, default 7: counter/config width, shall satisfy 2^WN > N_MAX.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port arst_n, input, 1 bit: asynchronous reset, active-low.
REQ-005 The block SHALL have port srst, input, 1 bit: synchronous reset, active-high.
REQ-006 The block SHALL have port enable, input, 1 bit: global clock-enable; 0 freezes all state.
REQ-007 The block SHALL have port in_valid, input, 1 bit: new operand set presented to datapath.
REQ-008 The block SHALL have port in_ready, output, 1 bit: controller can accept an operand set.
REQ-009 The block SHALL have port n_iter_cfg, input, WN bits: requested iteration count, sampled at accept.
REQ-010 The block SHALL have port load_en, output, 1 bit: datapath captures initial X/Y operands.
REQ-011 The block SHALL have port step_en, output, 1 bit: datapath executes one bkm_step and registers X_np1/Y_np1.
REQ-012 The block SHALL have port step_n, output, WN bits: current iteration index n driven to bkm_step.
REQ-013 The block SHALL have port out_valid, output, 1 bit: res_X/res_Y final and stable.
REQ-014 The block SHALL have port out_ready, input, 1 bit: consumer takes result.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, ITER, DONE.
REQ-016 IDLE SHALL assert in_ready=1, with all other outputs 0; when in_valid=1 and enable=1, load_en=1 combinationally, the count is latched, n<=0, and the FSM enters ITER.
REQ-017 Count latch SHALL be: n_iter_cfg=0 -> 1; n_iter_cfg>N_MAX -> N_MAX; otherwise n_iter_cfg.
REQ-018 ITER SHALL assert step_en=enable and step_n=n; on each enabled cycle, n<=n+1; when n==count-1, the FSM enters DONE instead, and n holds.
REQ-019 DONE SHALL assert out_valid=1 and hold step_n; on out_ready=1 with enable=1, the FSM enters IDLE; out_valid SHALL remain asserted until the handshake completes.
REQ-020 Latency SHALL be: accept at edge k -> out_valid high from edge k+count, with enable held 1.
REQ-021 in_ready SHALL be 0 in ITER and DONE; in_valid in those states SHALL be ignored and not queued.
REQ-022 enable=0 SHALL freeze state, n and count, force load_en=step_en=0, and keep in_ready/out_valid at their state values while blocking handshakes.
REQ-023 n SHALL never exceed N_MAX-1; no wrap-around SHALL occur.

Reset
REQ-024 arst_n=0 SHALL immediately force IDLE, n=0, count=1, in_ready=1, and load_en=step_en=out_valid=step_n=0.
REQ-025 srst=1 SHALL give the same result at the next edge, regardless of enable, with priority over any handshake in that cycle.
REQ-026 Reset mid-ITER or in DONE SHALL abandon the operation; no out_valid SHALL be produced for it.

Configuration
REQ-027 With macro BKM_CTRL_EARLY_ACCEPT_EN defined, DONE SHALL also assert in_ready=1; if out_ready and in_valid are both 1, the block SHALL complete the output, assert load_en, and enter ITER directly (back-to-back, no IDLE bubble).
REQ-028 Without BKM_CTRL_EARLY_ACCEPT_EN, in_ready SHALL be 0 in DONE and every operation SHALL pass through IDLE.

Verification
REQ-029 Assert arst_n=0 mid-ITER at n=5 -> outputs zero at once, in_ready=1, no out_valid afterwards.
REQ-030 With enable=1, n_iter_cfg=4 and in_valid pulse -> load_en for 1 cycle, step_en for 4 cycles with step_n=0,1,2,3, out_valid on the 4th edge after accept.
REQ-031 n_iter_cfg=0 -> exactly 1 step; n_iter_cfg=100 with N_MAX=64 -> exactly 64 steps, last step_n=63.
REQ-032 enable=0 for 3 cycles at step_n=2 with count 8 -> step_en=0 and step_n=2 held; total latency 8+3.
REQ-033 Hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1 and in_valid is ignored; srst=1 in DONE -> IDLE next edge.
REQ-034 With BKM_CTRL_EARLY_ACCEPT_EN, in_valid=1 and out_ready=1 in DONE -> load_en the same cycle and step_n=0 next cycle; without the macro -> one IDLE cycle first.
